// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch block.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [31:0] c_INST_STEP = 32'd4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small synchronous FIFO of {pc, inst} pairs feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
   parameter int QDEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [31:0]              push_pc,
   input  logic [31:0]              push_inst,
   input  logic                     pop,
   output logic [$clog2(QDEPTH):0]  count,
   output logic                     head_valid,
   output logic [31:0]              head_pc,
   output logic [31:0]              head_inst
);

   localparam int c_AW = $clog2(QDEPTH);
   localparam int c_CW = c_AW + 1;

   logic [31:0]     r_pc_mem   [QDEPTH];
   logic [31:0]     r_inst_mem [QDEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_CW-1:0] r_count;

   logic w_push;
   logic w_pop;

   assign w_push = push & ~flush;
   assign w_pop  = pop & ~flush & (r_count != '0);

   // Storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= push_pc;
         r_inst_mem[r_wr_ptr] <= push_inst;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign count      = r_count;
   assign head_valid = (r_count != '0);
   assign head_pc    = r_pc_mem[r_rd_ptr];
   assign head_inst  = r_inst_mem[r_rd_ptr];

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch controller: PC sequencing, single-outstanding
//               memory requests, redirect flush and fetch queue to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int          QDEPTH    = 2,
   parameter logic [31:0] INST_STEP = c_INST_STEP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   output logic [31:0] pc_in,
   output logic        pc_stall,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_gnt,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        id_stall
);

   localparam int c_CW = $clog2(QDEPTH) + 1;

   fetch_state_e    r_state;
   logic [31:0]     r_req_pc;

   logic [c_CW-1:0] w_count;
   logic            w_pop;
   logic            w_can_issue;
   logic            w_issue;
   logic            w_push;

   assign w_pop       = if_valid & ~id_stall;
   assign w_can_issue = (w_count < c_CW'(QDEPTH)) | w_pop;

   assign im_req   = (r_state == IDLE) & w_can_issue & ~ex_redirect;
   assign im_addr  = pc_cur;
   assign w_issue  = im_req & im_gnt;

   // The PC only moves on an accepted fetch or a redirect; an ungranted
   // request therefore sees a stable address.
   assign pc_in    = ex_redirect ? ex_target : (pc_cur + INST_STEP);
   assign pc_stall = ~(w_issue | ex_redirect);

   assign w_push   = (r_state == WAIT) & im_rvalid & ~ex_redirect;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_req_pc <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_state  <= WAIT;
                  r_req_pc <= pc_cur;
               end
            end
            WAIT: begin
               if (im_rvalid) begin
                  r_state <= IDLE;
               end else if (ex_redirect) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (im_rvalid) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (ex_redirect),
      .push       (w_push),
      .push_pc    (r_req_pc),
      .push_inst  (im_rdata),
      .pop        (w_pop),
      .count      (w_count),
      .head_valid (if_valid),
      .head_pc    (if_pc),
      .head_inst  (if_inst)
   );

endmodule : fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the PC register and shares it with redirect requests from execute. It drives the PC register's `pc_in`/`stall` and issues single-outstanding requests to instruction memory. Responses are buffered in a small fetch queue that feeds decode. On a redirect it flushes the queue and discards stale in-flight responses. It sits between the PC register, instruction memory and the IF/ID boundary.

## Interface
- `QDEPTH`, 2: fetch-queue entries; power of two, ≥2.
- `INST_STEP`, 4: byte increment of sequential PC.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pc_cur`  in  32  current PC from PC register output.
- `pc_in`  out  32  next PC to PC register.
- `pc_stall`  out  1  hold PC register.
- `ex_redirect`  in  1  single-cycle branch/jump/trap redirect.
- `ex_target`  in  32  redirect target, valid with `ex_redirect`.
- `im_req`  out  1  fetch request.
- `im_addr`  out  32  fetch address (= `pc_cur`).
- `im_gnt`  in  1  request accepted this cycle.
- `im_rvalid`  in  1  response valid; earliest one cycle after grant.
- `im_rdata`  in  32  instruction word.
- `if_valid`  out  1  queue head valid to decode.
- `if_pc`  out  32  PC of head instruction.
- `if_inst`  out  32  head instruction.
- `id_stall`  in  1  decode cannot accept head.

## Operation
- FSM states `IDLE` (nothing outstanding), `WAIT` (one request granted, response pending), `DRAIN` (pending response is stale and is discarded).
- pop = `if_valid & ~id_stall`. can_issue = (count < QDEPTH) | pop.
- `im_req` = `IDLE & can_issue & ~ex_redirect`. `im_addr` = `pc_cur`. The address stays stable while `im_req & ~im_gnt` because the PC is held.
- Issue = `im_req & im_gnt`. Latch `req_pc <= pc_cur`. Go to `WAIT`.
- `pc_in` = `ex_redirect ? ex_target : pc_cur + INST_STEP`. Arithmetic is 32-bit and wraps modulo 2^32.
- `pc_stall` = `~(issue | ex_redirect)`.
- `WAIT` with `im_rvalid`: push {`req_pc`, `im_rdata`}, then go to `IDLE`.
- `DRAIN` with `im_rvalid`: drop the data and go to `IDLE`.
- Redirect takes priority over every other event:
  - The queue is cleared (count→0) and push/pop that cycle are ignored.
  - From `IDLE`: stay in `IDLE`.
  - From `WAIT` without `im_rvalid`: go to `DRAIN`.
  - From `WAIT` or `DRAIN` with `im_rvalid`: the response is discarded and the next state is `IDLE`.
  - From `DRAIN` without `im_rvalid`: stay in `DRAIN`, and the PC takes the newest target.
- Push and pop in the same cycle keep count unchanged. Push into a full queue cannot occur because of the can_issue rule.
- `im_rvalid` in `IDLE` is a protocol error and is ignored.

## Timing
- Reset (`rst`=0): state `IDLE`, queue empty, count 0, `req_pc` 0, `if_valid` 0.
  - `im_req` = 1 once `rst` releases, provided `ex_redirect`=0.
  - Reset mid-request abandons the transaction; memory is reset by the same `rst`.
- All state changes happen on the rising `clk` edge. `im_req`, `pc_in` and `pc_stall` are combinational from state and inputs.
- Issue at cycle N: PC = old+4 at N+1.
- `im_rvalid` at M: `if_valid`=1 with that word at M+1.
- Peak throughput is one instruction per 2 cycles with a one-cycle memory.
- Redirect at cycle N:
  - `if_valid`=0 at N+1.
  - PC = target at N+1.
  - `im_req` at N+1 with `im_addr`=target if no response is outstanding. Otherwise it follows the discarded response.
- `id_stall` only holds the queue head. Fetch continues until count = QDEPTH.

## Structure
- `fetch_pkg`: `fetch_state_e` {IDLE, WAIT, DRAIN} and the `INST_STEP` default.
- Sub-module `fetch_queue`: synchronous FIFO of {pc, inst} with `push`, `pop`, `flush`, `count`, and head outputs.
  - `flush` takes priority over push/pop.
  - Pointers wrap modulo QDEPTH.
- `fetch_ctrl` instantiates `fetch_queue` and contains the FSM, PC next-value logic and `req_pc`.

## Test plan
- Reset release, one-cycle memory, no stalls:
  - Addresses 0x0, 0x4, 0x8 are issued every 2 cycles.
  - `if_pc` follows the same sequence with matching `if_inst`.
  - `pc_cur` reaches 0xC.
- `im_gnt` low for 3 cycles: `im_addr` holds 0x0 and `pc_stall`=1 throughout; the PC advances only on the grant cycle.
- `id_stall`=1 from reset:
  - Exactly 2 instructions (0x0, 0x4) are queued, then `im_req`=0.
  - Releasing the stall for 1 cycle pops 0x0 and re-enables the request for 0x8.
- `ex_redirect` with target 0x100 while in `WAIT`:
  - The stale response is dropped and `if_valid` stays 0.
  - The next request uses `im_addr`=0x100, followed by `if_pc`=0x100.
- Redirect to 0x200 in the same cycle as `im_rvalid`: the response is discarded, the queue is empty, and the next fetch is 0x200.
- Wrap-around: `pc_cur`=0xFFFF_FFFC issued yields `pc_in`=0x0.
